aes_cipher_control_n: RTL and testbench
=======================================

// Module: aes_cipher_control_n
// PURPOSE
// Cipher-side responder for the negated-polarity control handshake driven by the AES control FSM.
// Accepts requests (crypt, dec key gen, PRNG reseed, key/data clear) over an active-low valid/ready pair.
// Sequences round/key-expansion enables with a round counter and returns results on an active-low output handshake.
// Echoes request status back in inverted form. Sits between the control FSM and the cipher datapath.
// PARAMETERS
// SecMasking  1'b0  1: PRNG update pulse every round (masked core); 0: prng_update_o tied 0
// PORTS
// clk_i              in   1  clock
// rst_ni             in   1  async reset, active low
// in_valid_ni        in   1  request valid, active low
// in_ready_no        out  1  request ready, active low
// out_valid_no       out  1  result valid, active low
// out_ready_ni       in   1  result ready, active low
// op_i               in   2  CIPH_FWD=2'b01, CIPH_INV=2'b10; other codes illegal
// key_len_i          in   3  one-hot: 128=3'b001, 192=3'b010, 256=3'b100; other codes illegal
// crypt_ni / dec_key_gen_ni  in  1 each  request flags, active low
// prng_reseed_i / key_clear_i / data_out_clear_i  in  1 each  request flags, active high
// crypt_no / dec_key_gen_no  out  1 each  busy echo, active low
// prng_reseed_o / key_clear_o / data_out_clear_o  out  1 each  pending echo, active high
// prng_reseed_req_o  out  1  reseed request to PRNG
// prng_reseed_ack_i  in   1  reseed done
// round_o            out  4  current round index
// state_we_o         out  1  datapath state register write enable
// key_expand_en_o    out  1  key expansion step enable
// prng_update_o      out  1  masking PRNG update
// state_clear_o / key_clear_pulse_o  out  1 each  one-cycle clear strobes
// alert_o            out  1  fatal alert, sticky until reset
// BEHAVIOUR
// - Reset: state IDLE; active-low outputs = 1, active-high outputs = 0, round_o = 0. in_ready_no = 0 from first edge after release.
// - Accept on edge where in_valid_ni==0 && in_ready_no==0; only in IDLE. All request inputs latched; echoes set same edge.
// - Illegal op_i/key_len_i when crypt or dec_key_gen requested -> ERROR: alert_o=1, in_ready_no=1, all enables 0, until reset.
// - Priority after accept: clear > reseed > crypt/dec_key_gen. A request with no flag set returns to IDLE, no output handshake.
// - CLEAR: 1 cycle; state_clear_o pulses if data_out_clear, key_clear_pulse_o if key_clear; echoes drop next edge.
//   If crypt also requested, continues to RESEED/INIT instead of IDLE.
// - RESEED: prng_reseed_req_o=1 until prng_reseed_ack_i sampled 1; prng_reseed_o drops same edge; then INIT or IDLE.
// - Nr = 10/12/14 for 128/192/256. INIT: round_o=0, state_we_o=1, key_expand_en_o=1.
// - ROUND: round_o=1..Nr-1, one per cycle, all enables 1. FINISH: round_o=Nr, enables 1 on entry cycle only.
// - FINISH: out_valid_no=0 from entry, held (with round_o) until out_ready_ni==0 sampled; then crypt_no/dec_key_gen_no -> 1, IDLE.
// - Latency AES-128, no reseed/clear: accept edge t; out_valid_no falls at t+11.
// - dec_key_gen: same sequence, state_we_o forced 0 (key schedule only).
// - prng_update_o = state_we_o when SecMasking, else 0.
// - Round counter saturates; wrap past Nr -> ERROR. Reset mid-operation: immediate return to reset values, no partial strobes.
// - State encoding sparse (Hamming distance >= 3); any unencoded state -> ERROR.
// CONFIGURATION
// AES_CIPHER_CTRL_RND_CNT_DUP_EN defined: second, bit-inverted round counter kept in lockstep; any mismatch -> ERROR, alert_o=1.
// Undefined: single counter, no mismatch check, alert only from illegal inputs/states.
// STRUCTURE
// aes_pkg: ciph_op_e, key_len_e, cipher_ctrl_e (sparse state codes), Nr constants per key length.
// One sub-module: aes_cipher_round_cnt (counter, Nr compare, optional duplicate under the macro).
// TESTING
// - AES-128 fwd, out_ready_ni=0: round_o 0..10 on t+1..t+11; out_valid_no=0 at t+11; IDLE at t+12.
// - AES-256 inv, out_ready_ni=1 for 3 cycles in FINISH: round_o=14 and out_valid_no=0 held; enables 0 while stalled.
// - key_len_i=3'b011 with crypt_ni=0: alert_o=1 next edge, in_ready_no stays 1 until rst_ni pulse.
// - prng_reseed_i=1 + crypt, ack after 5 cycles: prng_reseed_req_o=1 for 5 cycles, then INIT round_o=0.
// - key_clear_i + data_out_clear_i: both strobes one cycle, echoes drop, no out_valid_no, back to IDLE.
// - rst_ni low at round 5; with macro, force duplicate-counter bit flip: alert_o=1, ERROR.

Source files
------------

// File: rtl/aes_pkg.sv
// -----------------------------------------------------------------------------
// aes_pkg
// Shared types and constants for the AES cipher-side control responder.
//   ciph_op_e     : cipher direction codes (only FWD/INV are legal)
//   key_len_e     : one-hot key length codes
//   cipher_ctrl_e : FSM state codes. These are codewords of a Hamming(7,4) code,
//                   so any two states differ in at least three bits and a
//                   single or double bit upset can never produce another
//                   valid state.
//   NR_AES_*      : number of rounds per key length
//   aes_nr()      : key length -> Nr
//   op_legal() / key_len_legal() : input code checks
// -----------------------------------------------------------------------------
package aes_pkg;

    typedef enum logic [1:0] {
        CIPH_FWD = 2'b01,
        CIPH_INV = 2'b10
    } ciph_op_e;

    typedef enum logic [2:0] {
        AES_128 = 3'b001,
        AES_192 = 3'b010,
        AES_256 = 3'b100
    } key_len_e;

    typedef enum logic [6:0] {
        CIPHER_CTRL_IDLE   = 7'b1101001,
        CIPHER_CTRL_CLEAR  = 7'b0101010,
        CIPHER_CTRL_RESEED = 7'b1000011,
        CIPHER_CTRL_INIT   = 7'b1001100,
        CIPHER_CTRL_ROUND  = 7'b0100101,
        CIPHER_CTRL_FINISH = 7'b1100110,
        CIPHER_CTRL_ERROR  = 7'b0011001
    } cipher_ctrl_e;

    localparam logic [3:0] NR_AES_128 = 4'd10;
    localparam logic [3:0] NR_AES_192 = 4'd12;
    localparam logic [3:0] NR_AES_256 = 4'd14;

    function automatic logic [3:0] aes_nr(input logic [2:0] key_len);
        logic [3:0] nr;
        case (key_len)
            AES_192: nr = NR_AES_192;
            AES_256: nr = NR_AES_256;
            default: nr = NR_AES_128;
        endcase
        return nr;
    endfunction

    function automatic logic op_legal(input logic [1:0] op);
        return (op == CIPH_FWD) || (op == CIPH_INV);
    endfunction

    function automatic logic key_len_legal(input logic [2:0] key_len);
        return (key_len == AES_128) || (key_len == AES_192) || (key_len == AES_256);
    endfunction

endpackage

// File: rtl/aes_cipher_round_cnt.sv
// -----------------------------------------------------------------------------
// aes_cipher_round_cnt
// Round counter for the cipher control FSM. Clears to 0, increments by one
// per enabled cycle and saturates at 15. Flags the last regular round
// (count == Nr-1) and raises err_o if the count ever exceeds Nr.
//
// Optional feature (macro AES_CIPHER_CTRL_RND_CNT_DUP_EN):
//   a second counter holding the bit-inverted count is kept in lockstep;
//   any disagreement between the two raises err_o.
//
// Ports
//   clk_i   in   clock
//   rst_ni  in   async reset, active low
//   clr_i   in   load 0 (wins over inc_i)
//   inc_i   in   increment (saturating)
//   nr_i    in   [3:0] number of rounds for the active key length
//   cnt_o   out  [3:0] current count
//   last_o  out  count == Nr-1
//   err_o   out  count beyond Nr, or duplicate mismatch when enabled
// -----------------------------------------------------------------------------
module aes_cipher_round_cnt (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       clr_i,
    input  logic       inc_i,
    input  logic [3:0] nr_i,
    output logic [3:0] cnt_o,
    output logic       last_o,
    output logic       err_o
);

    logic [3:0] cnt_d;
    logic [3:0] cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = 4'd0;
        end else if (inc_i && (cnt_q != 4'hF)) begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign last_o = (cnt_q == (nr_i - 4'd1));

`ifdef AES_CIPHER_CTRL_RND_CNT_DUP_EN
    // Inverted shadow copy: a single upset in either register breaks the
    // complement relation and is caught on the next cycle.
    logic [3:0] cnt_n_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_n_q <= 4'hF;
        end else begin
            cnt_n_q <= ~cnt_d;
        end
    end

    assign err_o = (cnt_q > nr_i) || (cnt_q != ~cnt_n_q);
`else
    assign err_o = (cnt_q > nr_i);
`endif

endmodule

// File: rtl/aes_cipher_control_n.sv
// -----------------------------------------------------------------------------
// aes_cipher_control_n
// Cipher-side responder for the active-low control handshake coming from the
// AES control FSM. Accepts a request in IDLE, then runs
//   CLEAR (optional) -> RESEED (optional) -> INIT -> ROUND x (Nr-1) -> FINISH
// and returns the result over an active-low valid/ready pair. Request flags
// are echoed back (busy flags inverted, pending flags active high) until the
// corresponding phase has completed.
//
// Parameter
//   SecMasking : 1 -> prng_update_o follows state_we_o; 0 -> prng_update_o = 0
//
// Optional feature (macro AES_CIPHER_CTRL_RND_CNT_DUP_EN):
//   duplicated, inverted round counter in aes_cipher_round_cnt; a mismatch
//   drives the FSM into ERROR.
//
// Ports
//   clk_i, rst_ni                  clock, async reset (active low)
//   in_valid_ni / in_ready_no      request handshake (active low)
//   out_valid_no / out_ready_ni    result handshake (active low)
//   op_i [1:0], key_len_i [2:0]    cipher direction, one-hot key length
//   crypt_ni, dec_key_gen_ni       request flags (active low)
//   prng_reseed_i, key_clear_i, data_out_clear_i  request flags (active high)
//   crypt_no, dec_key_gen_no       busy echoes (active low)
//   prng_reseed_o, key_clear_o, data_out_clear_o  pending echoes
//   prng_reseed_req_o / _ack_i     PRNG reseed handshake
//   round_o [3:0]                  current round index
//   state_we_o, key_expand_en_o    datapath enables
//   prng_update_o                  masking PRNG update
//   state_clear_o, key_clear_pulse_o  one-cycle clear strobes
//   alert_o                        fatal alert, sticky until reset
// -----------------------------------------------------------------------------
module aes_cipher_control_n #(
    parameter logic SecMasking = 1'b0
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       in_valid_ni,
    output logic       in_ready_no,
    output logic       out_valid_no,
    input  logic       out_ready_ni,
    input  logic [1:0] op_i,
    input  logic [2:0] key_len_i,
    input  logic       crypt_ni,
    input  logic       dec_key_gen_ni,
    input  logic       prng_reseed_i,
    input  logic       key_clear_i,
    input  logic       data_out_clear_i,
    output logic       crypt_no,
    output logic       dec_key_gen_no,
    output logic       prng_reseed_o,
    output logic       key_clear_o,
    output logic       data_out_clear_o,
    output logic       prng_reseed_req_o,
    input  logic       prng_reseed_ack_i,
    output logic [3:0] round_o,
    output logic       state_we_o,
    output logic       key_expand_en_o,
    output logic       prng_update_o,
    output logic       state_clear_o,
    output logic       key_clear_pulse_o,
    output logic       alert_o
);
    import aes_pkg::*;

    cipher_ctrl_e state_d;
    cipher_ctrl_e state_q;

    logic       in_ready_n_q;
    logic [2:0] key_len_q;
    logic       crypt_q;
    logic       dkg_q;
    logic       reseed_q;
    logic       key_clr_q;
    logic       data_clr_q;
    logic       fin_entry_q;

    logic       accept;
    logic       req_cipher;
    logic       req_legal;
    logic       round_en;
    logic       out_valid;
    logic       reseed_req;
    logic       state_clr;
    logic       key_clr_pulse;
    logic       alert;
    logic       reseed_done;
    logic       finish_done;

    logic       cnt_clr;
    logic       cnt_inc;
    logic       cnt_last;
    logic       cnt_err;
    logic [3:0] cnt;
    logic [3:0] nr;

    assign accept     = (state_q == CIPHER_CTRL_IDLE) && !in_valid_ni && !in_ready_n_q;
    assign req_cipher = !crypt_ni || !dec_key_gen_ni;
    assign req_legal  = op_legal(op_i) && key_len_legal(key_len_i);
    assign nr         = aes_nr(key_len_q);

    // Next-state and Moore outputs.
    always_comb begin
        state_d       = state_q;
        round_en      = 1'b0;
        out_valid     = 1'b0;
        reseed_req    = 1'b0;
        state_clr     = 1'b0;
        key_clr_pulse = 1'b0;
        alert         = 1'b0;
        reseed_done   = 1'b0;
        finish_done   = 1'b0;

        case (state_q)
            CIPHER_CTRL_IDLE: begin
                if (accept) begin
                    // Direction and key length only matter when the round
                    // datapath is going to run.
                    if (req_cipher && !req_legal) begin
                        state_d = CIPHER_CTRL_ERROR;
                    end else if (key_clear_i || data_out_clear_i) begin
                        state_d = CIPHER_CTRL_CLEAR;
                    end else if (prng_reseed_i) begin
                        state_d = CIPHER_CTRL_RESEED;
                    end else if (req_cipher) begin
                        state_d = CIPHER_CTRL_INIT;
                    end
                end
            end

            CIPHER_CTRL_CLEAR: begin
                state_clr     = data_clr_q;
                key_clr_pulse = key_clr_q;
                if (reseed_q) begin
                    state_d = CIPHER_CTRL_RESEED;
                end else if (crypt_q || dkg_q) begin
                    state_d = CIPHER_CTRL_INIT;
                end else begin
                    state_d = CIPHER_CTRL_IDLE;
                end
            end

            CIPHER_CTRL_RESEED: begin
                reseed_req = 1'b1;
                if (prng_reseed_ack_i) begin
                    reseed_done = 1'b1;
                    state_d     = (crypt_q || dkg_q) ? CIPHER_CTRL_INIT : CIPHER_CTRL_IDLE;
                end
            end

            CIPHER_CTRL_INIT: begin
                round_en = 1'b1;
                state_d  = CIPHER_CTRL_ROUND;
            end

            CIPHER_CTRL_ROUND: begin
                round_en = 1'b1;
                if (cnt_last) begin
                    state_d = CIPHER_CTRL_FINISH;
                end
            end

            CIPHER_CTRL_FINISH: begin
                // The final round runs once; stalled cycles only hold the result.
                round_en  = fin_entry_q;
                out_valid = 1'b1;
                if (!out_ready_ni) begin
                    finish_done = 1'b1;
                    state_d     = CIPHER_CTRL_IDLE;
                end
            end

            CIPHER_CTRL_ERROR: begin
                alert = 1'b1;
            end

            default: begin
                alert   = 1'b1;
                state_d = CIPHER_CTRL_ERROR;
            end
        endcase

        if (cnt_err) begin
            state_d = CIPHER_CTRL_ERROR;
        end
    end

    // Round counter control: zero outside the round phase, one step per
    // INIT/ROUND cycle, frozen in FINISH and ERROR.
    assign cnt_clr = (state_d == CIPHER_CTRL_IDLE)  || (state_d == CIPHER_CTRL_CLEAR) ||
                     (state_d == CIPHER_CTRL_RESEED) || (state_d == CIPHER_CTRL_INIT);
    assign cnt_inc = ((state_q == CIPHER_CTRL_INIT) || (state_q == CIPHER_CTRL_ROUND)) &&
                     ((state_d == CIPHER_CTRL_ROUND) || (state_d == CIPHER_CTRL_FINISH));

    aes_cipher_round_cnt u_round_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (cnt_clr),
        .inc_i  (cnt_inc),
        .nr_i   (nr),
        .cnt_o  (cnt),
        .last_o (cnt_last),
        .err_o  (cnt_err)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= CIPHER_CTRL_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            in_ready_n_q <= 1'b1;
            fin_entry_q  <= 1'b0;
            key_len_q    <= AES_128;
            crypt_q      <= 1'b0;
            dkg_q        <= 1'b0;
            reseed_q     <= 1'b0;
            key_clr_q    <= 1'b0;
            data_clr_q   <= 1'b0;
        end else begin
            in_ready_n_q <= (state_d != CIPHER_CTRL_IDLE);
            fin_entry_q  <= (state_d == CIPHER_CTRL_FINISH) && (state_q != CIPHER_CTRL_FINISH);

            if (accept) begin
                key_len_q  <= key_len_i;
                crypt_q    <= ~crypt_ni;
                dkg_q      <= ~dec_key_gen_ni;
                reseed_q   <= prng_reseed_i;
                key_clr_q  <= key_clear_i;
                data_clr_q <= data_out_clear_i;
            end
            if (state_q == CIPHER_CTRL_CLEAR) begin
                key_clr_q  <= 1'b0;
                data_clr_q <= 1'b0;
            end
            if (reseed_done) begin
                reseed_q <= 1'b0;
            end
            if (finish_done) begin
                crypt_q <= 1'b0;
                dkg_q   <= 1'b0;
            end
        end
    end

    assign in_ready_no       = in_ready_n_q;
    assign out_valid_no      = ~out_valid;
    assign crypt_no          = ~crypt_q;
    assign dec_key_gen_no    = ~dkg_q;
    assign prng_reseed_o     = reseed_q;
    assign key_clear_o       = key_clr_q;
    assign data_out_clear_o  = data_clr_q;
    assign prng_reseed_req_o = reseed_req;
    assign round_o           = cnt;
    assign key_expand_en_o   = round_en;
    // Key-schedule-only runs must leave the data state untouched.
    assign state_we_o        = round_en && !dkg_q;
    assign state_clear_o     = state_clr;
    assign key_clear_pulse_o = key_clr_pulse;
    assign alert_o           = alert;

    if (SecMasking) begin : g_masked
        assign prng_update_o = state_we_o;
    end else begin : g_unmasked
        assign prng_update_o = 1'b0;
    end

endmodule

// File: tb/tb_aes_cipher_control_n.sv
module tb_aes_cipher_control_n;

    logic       clk_i = 1'b0;
    logic       rst_ni = 1'b0;
    logic       in_valid_ni = 1'b1;
    logic       in_ready_no;
    logic       out_valid_no;
    logic       out_ready_ni = 1'b1;
    logic [1:0] op_i = 2'b01;
    logic [2:0] key_len_i = 3'b001;
    logic       crypt_ni = 1'b1;
    logic       dec_key_gen_ni = 1'b1;
    logic       prng_reseed_i = 1'b0;
    logic       key_clear_i = 1'b0;
    logic       data_out_clear_i = 1'b0;
    logic       crypt_no;
    logic       dec_key_gen_no;
    logic       prng_reseed_o;
    logic       key_clear_o;
    logic       data_out_clear_o;
    logic       prng_reseed_req_o;
    logic       prng_reseed_ack_i = 1'b0;
    logic [3:0] round_o;
    logic       state_we_o;
    logic       key_expand_en_o;
    logic       prng_update_o;
    logic       state_clear_o;
    logic       key_clear_pulse_o;
    logic       alert_o;

    int n_checks = 0;
    int n_fail   = 0;
    int n_tx     = 0;

    always #5 clk_i = ~clk_i;

    aes_cipher_control_n #(
        .SecMasking (1'b1)
    ) dut (
        .clk_i             (clk_i),
        .rst_ni            (rst_ni),
        .in_valid_ni       (in_valid_ni),
        .in_ready_no       (in_ready_no),
        .out_valid_no      (out_valid_no),
        .out_ready_ni      (out_ready_ni),
        .op_i              (op_i),
        .key_len_i         (key_len_i),
        .crypt_ni          (crypt_ni),
        .dec_key_gen_ni    (dec_key_gen_ni),
        .prng_reseed_i     (prng_reseed_i),
        .key_clear_i       (key_clear_i),
        .data_out_clear_i  (data_out_clear_i),
        .crypt_no          (crypt_no),
        .dec_key_gen_no    (dec_key_gen_no),
        .prng_reseed_o     (prng_reseed_o),
        .key_clear_o       (key_clear_o),
        .data_out_clear_o  (data_out_clear_o),
        .prng_reseed_req_o (prng_reseed_req_o),
        .prng_reseed_ack_i (prng_reseed_ack_i),
        .round_o           (round_o),
        .state_we_o        (state_we_o),
        .key_expand_en_o   (key_expand_en_o),
        .prng_update_o     (prng_update_o),
        .state_clear_o     (state_clear_o),
        .key_clear_pulse_o (key_clear_pulse_o),
        .alert_o           (alert_o)
    );

    // Observed output bundle, same field order as ev().
    logic [17:0] status;
    assign status = {alert_o, in_ready_no, out_valid_no, prng_reseed_req_o, state_clear_o,
                     key_clear_pulse_o, state_we_o, key_expand_en_o, prng_update_o, round_o,
                     crypt_no, dec_key_gen_no, prng_reseed_o, key_clear_o, data_out_clear_o};

    // Expected bundle; prng_update_o must equal state_we_o with masking on.
    function automatic logic [17:0] ev(input bit alert, input bit rdy_n, input bit ov_n,
                                       input bit rreq, input bit sclr, input bit kp,
                                       input bit we, input bit ke, input logic [3:0] rnd,
                                       input bit c, input bit d, input bit rs,
                                       input bit kc, input bit dc);
        return {alert, rdy_n, ov_n, rreq, sclr, kp, we, ke, we, rnd, ~c, ~d, rs, kc, dc};
    endfunction

    logic [17:0] rst_vec;
    logic [17:0] idle_vec;

    task automatic check_value(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (tx %0d): got %h expected %h", tag, n_tx, act, exp);
        end
    endtask

    // One cycle: check outputs presented to the coming edge, then return
    // inputs to their idle levels (callers override afterwards).
    task automatic step(input string tag, input logic [17:0] exp);
        @(negedge clk_i);
        check_value(tag, {14'd0, status}, {14'd0, exp});
        in_valid_ni       = 1'b1;
        prng_reseed_ack_i = 1'b0;
        out_ready_ni      = 1'b1;
    endtask

    task automatic pulse_reset(input string tag);
        rst_ni = 1'b0;
        #1;
        check_value({tag, "_async"}, {14'd0, status}, {14'd0, rst_vec});
        step({tag, "_hold"}, rst_vec);
        rst_ni = 1'b1;
        step({tag, "_idle"}, idle_vec);
    endtask

    task automatic drive_req(input bit c, input bit d, input bit rs, input bit kc, input bit dc,
                             input logic [1:0] op, input logic [2:0] kl);
        in_valid_ni      = 1'b0;
        crypt_ni         = ~c;
        dec_key_gen_ni   = ~d;
        prng_reseed_i    = rs;
        key_clear_i      = kc;
        data_out_clear_i = dc;
        op_i             = op;
        key_len_i        = kl;
    endtask

    // Reference: the expected cycle trace of one request, built phase by phase
    // from the protocol rules. Entered just after an idle-cycle check.
    task automatic do_req(input bit c, input bit d, input bit rs, input bit kc, input bit dc,
                          input logic [1:0] op, input logic [2:0] kl,
                          input int ack_dly, input int stall);
        bit e_c, e_d, e_rs, e_kc, e_dc;
        int nr;
        e_c = c; e_d = d; e_rs = rs; e_kc = kc; e_dc = dc;
        nr = (kl == 3'b001) ? 10 : ((kl == 3'b010) ? 12 : 14);
        n_tx++;
        $display("tx %0d: crypt=%0b dkg=%0b reseed=%0b kclr=%0b dclr=%0b op=%b klen=%b ack_dly=%0d stall=%0d",
                 n_tx, c, d, rs, kc, dc, op, kl, ack_dly, stall);
        drive_req(c, d, rs, kc, dc, op, kl);
        if (kc || dc) begin
            step("clear", ev(0, 1, 1, 0, dc, kc, 0, 0, 4'd0, e_c, e_d, e_rs, e_kc, e_dc));
            e_kc = 1'b0;
            e_dc = 1'b0;
        end
        if (rs) begin
            for (int i = 1; i <= ack_dly; i++) begin
                step("reseed", ev(0, 1, 1, 1, 0, 0, 0, 0, 4'd0, e_c, e_d, e_rs, e_kc, e_dc));
                if (i == ack_dly) prng_reseed_ack_i = 1'b1;
            end
            e_rs = 1'b0;
        end
        if (c || d) begin
            for (int r = 0; r < nr; r++) begin
                step("round", ev(0, 1, 1, 0, 0, 0, !d, 1, 4'(r), e_c, e_d, e_rs, e_kc, e_dc));
            end
            for (int j = 0; j <= stall; j++) begin
                step("finish", ev(0, 1, 0, 0, 0, 0, (j == 0) && !d, (j == 0), 4'(nr),
                                  e_c, e_d, e_rs, e_kc, e_dc));
                if (j == stall) out_ready_ni = 1'b0;
            end
            e_c = 1'b0;
            e_d = 1'b0;
        end
        step("idle", ev(0, 0, 1, 0, 0, 0, 0, 0, 4'd0, e_c, e_d, e_rs, e_kc, e_dc));
    endtask

    // Illegal codes with a cipher request: ERROR with alert, ready stays high
    // even while further requests are offered, until a reset pulse.
    task automatic do_illegal(input bit c, input bit d, input logic [1:0] op, input logic [2:0] kl);
        n_tx++;
        $display("tx %0d: illegal crypt=%0b dkg=%0b op=%b klen=%b", n_tx, c, d, op, kl);
        drive_req(c, d, 1'b0, 1'b0, 1'b0, op, kl);
        for (int i = 0; i < 3; i++) begin
            step("error", ev(1, 1, 1, 0, 0, 0, 0, 0, 4'd0, c, d, 0, 0, 0));
            in_valid_ni = 1'b0;
        end
        step("error_hold", ev(1, 1, 1, 0, 0, 0, 0, 0, 4'd0, c, d, 0, 0, 0));
        pulse_reset("err_rst");
    endtask

    initial begin
        rst_vec  = ev(0, 1, 1, 0, 0, 0, 0, 0, 4'd0, 0, 0, 0, 0, 0);
        idle_vec = ev(0, 0, 1, 0, 0, 0, 0, 0, 4'd0, 0, 0, 0, 0, 0);

        step("reset", rst_vec);
        step("reset", rst_vec);
        rst_ni = 1'b1;
        step("post_reset_idle", idle_vec);

        // AES-128 forward, result taken immediately.
        do_req(1, 0, 0, 0, 0, 2'b01, 3'b001, 1, 0);
        // AES-256 inverse, result stalled for 3 cycles.
        do_req(1, 0, 0, 0, 0, 2'b10, 3'b100, 1, 3);
        // Reseed before crypt, ack after 5 cycles.
        do_req(1, 0, 1, 0, 0, 2'b01, 3'b010, 5, 0);
        // Both clears, no crypt.
        do_req(0, 0, 0, 1, 1, 2'b01, 3'b001, 1, 0);
        // Clear with illegal codes but no cipher request is still a plain clear.
        do_req(0, 0, 0, 1, 0, 2'b00, 3'b011, 1, 0);
        // Key schedule only.
        do_req(0, 1, 0, 0, 0, 2'b10, 3'b001, 1, 1);
        // Empty request.
        do_req(0, 0, 0, 0, 0, 2'b01, 3'b001, 1, 0);
        // Clear + reseed + crypt chained.
        do_req(1, 0, 1, 0, 1, 2'b01, 3'b100, 2, 2);

        do_illegal(1, 0, 2'b01, 3'b011);
        do_illegal(0, 1, 2'b11, 3'b001);

        for (int t = 0; t < 40; t++) begin
            int mode;
            logic [2:0] kl;
            mode = int'($urandom_range(0, 2));
            case ($urandom_range(0, 2))
                0:       kl = 3'b001;
                1:       kl = 3'b010;
                default: kl = 3'b100;
            endcase
            do_req(mode == 1, mode == 2, 1'($urandom), 1'($urandom), 1'($urandom),
                   ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10, kl,
                   int'($urandom_range(1, 6)), int'($urandom_range(0, 3)));
        end

        // Reset in the middle of round 5.
        n_tx++;
        $display("tx %0d: reset during round 5", n_tx);
        drive_req(1, 0, 0, 0, 0, 2'b01, 3'b001);
        for (int r = 0; r <= 5; r++) begin
            step("pre_rst_round", ev(0, 1, 1, 0, 0, 0, 1, 1, 4'(r), 1, 0, 0, 0, 0));
        end
        pulse_reset("mid_rst");
        do_req(1, 0, 0, 0, 0, 2'b01, 3'b001, 1, 0);

`ifdef AES_CIPHER_CTRL_RND_CNT_DUP_EN
        n_tx++;
        $display("tx %0d: duplicate counter corruption", n_tx);
        drive_req(1, 0, 0, 0, 0, 2'b01, 3'b001);
        for (int r = 0; r <= 3; r++) begin
            step("dup_round", ev(0, 1, 1, 0, 0, 0, 1, 1, 4'(r), 1, 0, 0, 0, 0));
        end
        force dut.u_round_cnt.cnt_n_q = 4'h0;
        @(negedge clk_i);
        check_value("dup_alert", {31'd0, alert_o}, 32'd1);
        check_value("dup_in_ready_n", {31'd0, in_ready_no}, 32'd1);
        check_value("dup_we", {31'd0, state_we_o}, 32'd0);
        release dut.u_round_cnt.cnt_n_q;
        pulse_reset("dup_rst");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
